iter_div: RTL and testbench
===========================

# iter_div

Multi-cycle sequential divider for the EX stage, producing quotient and remainder for unsigned and signed 16-bit division. It performs the inverse of the ALU's single-cycle multiply path and replaces a combinational divide with a 16-iteration restoring algorithm. The pipeline control stalls on `busy` while a divide is in flight. Operand naming matches the ALU: `src1` is the dividend and `src0` is the divisor.

## Interface
- No parameters. Width is fixed at 16 bits.
- `clk`  in  1  System clock; all state changes on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `start`  in  1  Request a divide. Accepted only in IDLE.
- `sgn`  in  1  Operation select: 1 = signed (SDIV), 0 = unsigned (DIV). Sampled with `start`.
- `src1`  in  16  Dividend, sampled with `start`.
- `src0`  in  16  Divisor, sampled with `start`.
- `busy`  out  1  High while state is not IDLE.
- `done`  out  1  One-cycle pulse. `quot`, `rem`, `dz` and `ov` are valid in that cycle.
- `quot`  out  16  Quotient, registered.
- `rem`  out  16  Remainder, registered.
- `dz`  out  1  Divide-by-zero flag, registered.
- `ov`  out  1  Signed overflow flag, registered.

## Operation
- States are IDLE, CALC and DONE.
- IDLE → CALC when `start`=1.
  - Operands are latched.
  - In signed mode, operand magnitudes are latched as two's-complement absolute values.
  - The sign-fix bits are latched: quotient sign = `src1[15]^src0[15]`, remainder sign = `src1[15]`.
  - The 4-bit iteration counter is set to 15.
- CALC runs for 16 cycles.
  - Each cycle: shift {partial remainder, dividend} left by 1, then trial-subtract the divisor magnitude.
  - On non-negative result, keep the difference and shift in quotient bit 1. Otherwise restore and shift in 0.
  - The counter decrements. Leave CALC when the counter is 0 after that cycle's iteration.
- CALC → DONE. On that edge, `quot`, `rem`, `dz` and `ov` are loaded with the sign-corrected results. DONE lasts 1 cycle with `done`=1, then the FSM returns to IDLE.
- Arithmetic rules:
  - Unsigned: `quot` = floor(src1/src0), `rem` = src1 mod src0.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign; |rem| < |src0|.
  - 0x8000 magnitude is handled as unsigned 0x8000 (17th bit not needed).
- Divide by zero (`src0`=0, either mode):
  - `quot`=16'hFFFF, `rem`=`src1` (unmodified), `dz`=1, `ov`=0.
  - Normal 17-cycle latency is kept.
- Signed overflow (`src1`=16'h8000, `src0`=16'hFFFF, `sgn`=1):
  - Result saturates, consistent with ALU saturating arithmetic: `quot`=16'h7FFF, `rem`=0, `ov`=1.
- Otherwise `dz`=0 and `ov`=0.
- Output registers hold their values from DONE until the next DONE. They do not change on `start` or during CALC.
- `start` while `busy`=1, including in the DONE cycle, is ignored and not queued.

## Timing
- Reset: state=IDLE, `busy`=0, `done`=0, `quot`=0, `rem`=0, `dz`=0, `ov`=0, counter=0.
- `rst` overrides `start` in the same cycle.
- `start` sampled at edge E0: `busy`=1 from E0 onward; cycles E0..E16 are CALC.
- DONE is entered at edge E16. `done`=1 and results are valid in cycle E16→E17.
- IDLE at E17, so `busy`=0 from E17. A new `start` is accepted at E17 earliest, giving a throughput of one divide per 17 cycles.
- Latency from the accepting edge to `done`: 16 cycles. `busy` is high for 17 cycles.
- `rst` mid-operation (CALC or DONE): abort at that edge. No `done` pulse; outputs go to reset values.
- `src0`, `src1` and `sgn` may change freely after the accepting edge.

## Test plan
- Unsigned: src1=100, src0=7, sgn=0 → `quot`=14, `rem`=2, `dz`=0, `ov`=0, with `done` exactly 16 cycles after the `start` edge.
- Signed: src1=0xFF9C (−100), src0=7 → `quot`=0xFFF2 (−14), `rem`=0xFFFE (−2). Repeat with src0=0xFFF9 (−7) → `quot`=14, `rem`=0xFFFE.
- Overflow/extremes:
  - signed 0x8000/0xFFFF → `quot`=0x7FFF, `rem`=0, `ov`=1.
  - unsigned 0x8000/0xFFFF → `quot`=0, `rem`=0x8000.
  - signed 0x8000/2 → `quot`=0xC000.
- Divide by zero: src1=0x1234, src0=0, both modes → `quot`=0xFFFF, `rem`=0x1234, `dz`=1 after 16 cycles.
- Handshake:
  - Pulse `start` with new operands during CALC and again during DONE → both ignored; first result intact.
  - `start` in the first IDLE cycle after `done` → accepted.
  - `busy` is high for exactly 17 cycles.
- Reset mid-op: assert `rst` at iteration 8 → no `done`, all outputs 0, `busy`=0. The next `start` (50/5) yields `quot`=10, `rem`=0.

Source files
------------

// File: rtl/iter_div.sv
// iter_div: 16-bit restoring divider, unsigned and signed, one quotient bit
// per cycle. The FSM takes 16 CALC cycles and 1 DONE cycle per divide.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; output registers hold the last result
// CALC  | 16 restoring iterations; cnt counts down from 15 to 0
// DONE  | done=1 for one cycle with results valid, then back to IDLE
module iter_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [15:0] src1,
  input  logic [15:0] src0,
  output logic        busy,
  output logic        done,
  output logic [15:0] quot,
  output logic [15:0] rem,
  output logic        dz,
  output logic        ov
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] dvd;       // dividend shifting out, quotient shifting in
  logic [15:0] prem;      // partial remainder
  logic [15:0] dsr;       // divisor magnitude
  logic [15:0] dvd_raw;   // original dividend, returned as rem on divide by zero
  logic        qneg;
  logic        rneg;
  logic        dz_p;
  logic        ov_p;

  logic [15:0] mag1;
  logic [15:0] mag0;
  logic [16:0] shifted;
  logic        ge;
  logic [15:0] diff;
  logic [15:0] prem_nx;
  logic [15:0] dvd_nx;
  logic [15:0] quot_fix;
  logic [15:0] rem_fix;

  // Operand magnitudes; 0x8000 negates to itself and reads correctly as unsigned.
  always_comb begin
    mag1 = (sgn && src1[15]) ? (16'd0 - src1) : src1;
    mag0 = (sgn && src0[15]) ? (16'd0 - src0) : src0;
  end

  // One restoring iteration plus sign correction of the would-be final result.
  always_comb begin
    shifted  = {prem, dvd[15]};
    ge       = (shifted >= {1'b0, dsr});
    // When ge holds the true difference is below dsr, so 16 bits are enough.
    diff     = shifted[15:0] - dsr;
    prem_nx  = ge ? diff : shifted[15:0];
    dvd_nx   = {dvd[14:0], ge};
    quot_fix = qneg ? (16'd0 - dvd_nx) : dvd_nx;
    rem_fix  = rneg ? (16'd0 - prem_nx) : prem_nx;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      dvd     <= 16'd0;
      prem    <= 16'd0;
      dsr     <= 16'd0;
      dvd_raw <= 16'd0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      dz_p    <= 1'b0;
      ov_p    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      quot    <= 16'd0;
      rem     <= 16'd0;
      dz      <= 1'b0;
      ov      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= CALC;
            busy    <= 1'b1;
            cnt     <= 4'd15;
            dvd     <= mag1;
            dsr     <= mag0;
            prem    <= 16'd0;
            dvd_raw <= src1;
            qneg    <= sgn & (src1[15] ^ src0[15]);
            rneg    <= sgn & src1[15];
            dz_p    <= (src0 == 16'd0);
            ov_p    <= sgn && (src1 == 16'h8000) && (src0 == 16'hFFFF);
          end
        end
        CALC: begin
          dvd  <= dvd_nx;
          prem <= prem_nx;
          if (cnt == 4'd0) begin
            state <= DONE;
            done  <= 1'b1;
            if (dz_p) begin
              quot <= 16'hFFFF;
              rem  <= dvd_raw;
              dz   <= 1'b1;
              ov   <= 1'b0;
            end else if (ov_p) begin
              quot <= 16'h7FFF;
              rem  <= 16'd0;
              dz   <= 1'b0;
              ov   <= 1'b1;
            end else begin
              quot <= quot_fix;
              rem  <= rem_fix;
              dz   <= 1'b0;
              ov   <= 1'b0;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed vectors with hand-computed results for iter_div.
module tb_iter_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [15:0] src1;
  logic [15:0] src0;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        dz;
  logic        ov;

  int n_chk;
  int n_err;

  iter_div dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sgn  (sgn),
    .src1 (src1),
    .src0 (src0),
    .busy (busy),
    .done (done),
    .quot (quot),
    .rem  (rem),
    .dz   (dz),
    .ov   (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Start is sampled at the next posedge (E0); returns 1 time unit after E0
  // with the operands scrambled, since they may change after acceptance.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    start = 1'b1;
    src1  = a;
    src0  = b;
    sgn   = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    src1  = 16'($urandom);
    src0  = 16'($urandom);
    sgn   = ~s;
  endtask

  // Follows one divide from E0+1 until busy drops. With poke set, start is
  // pulsed with other operands during CALC and during the DONE cycle.
  task automatic finish_div(input string tag, input logic [15:0] eq, input logic [15:0] er,
                            input logic edz, input logic eov, input bit poke);
    int lat;
    int bcnt;
    logic [15:0] q_s;
    logic [15:0] r_s;
    logic dz_s;
    logic ov_s;
    lat  = -1;
    bcnt = busy ? 1 : 0;
    q_s  = 16'd0;
    r_s  = 16'd0;
    dz_s = 1'b0;
    ov_s = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy) bcnt++;
      if (done && lat < 0) begin
        lat  = k;
        q_s  = quot;
        r_s  = rem;
        dz_s = dz;
        ov_s = ov;
      end
      if (!busy) break;
      if (poke && (k == 5 || k == 16)) begin
        start = 1'b1;
        src1  = 16'h0050;
        src0  = 16'h0003;
        sgn   = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, ".lat"},  32'(lat),  32'd16);
    chk({tag, ".busy"}, 32'(bcnt), 32'd17);
    chk({tag, ".quot"}, 32'(q_s),  32'(eq));
    chk({tag, ".rem"},  32'(r_s),  32'(er));
    chk({tag, ".dz"},   32'(dz_s), 32'(edz));
    chk({tag, ".ov"},   32'(ov_s), 32'(eov));
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [15:0] eq, input logic [15:0] er,
                         input logic edz, input logic eov);
    launch(a, b, s);
    finish_div(tag, eq, er, edz, eov, 1'b0);
  endtask

  initial begin
    int dcnt;
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b1;
    sgn   = 1'b0;
    src1  = 16'd100;
    src0  = 16'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.quot", 32'(quot), 32'd0);
    chk("rst.rem",  32'(rem),  32'd0);
    chk("rst.dz",   32'(dz),   32'd0);
    chk("rst.ov",   32'(ov),   32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.nostart", 32'(busy), 32'd0);

    run_div("u100_7",    16'd100,   16'd7,     1'b0, 16'd14,    16'd2,     1'b0, 1'b0);
    run_div("s-100_7",   16'hFF9C,  16'd7,     1'b1, 16'hFFF2,  16'hFFFE,  1'b0, 1'b0);
    run_div("s-100_-7",  16'hFF9C,  16'hFFF9,  1'b1, 16'h000E,  16'hFFFE,  1'b0, 1'b0);
    run_div("s7_-2",     16'd7,     16'hFFFE,  1'b1, 16'hFFFD,  16'h0001,  1'b0, 1'b0);
    run_div("s-7_2",     16'hFFF9,  16'd2,     1'b1, 16'hFFFD,  16'hFFFF,  1'b0, 1'b0);
    run_div("s_ovf",     16'h8000,  16'hFFFF,  1'b1, 16'h7FFF,  16'h0000,  1'b0, 1'b1);
    run_div("u8000_ffff",16'h8000,  16'hFFFF,  1'b0, 16'h0000,  16'h8000,  1'b0, 1'b0);
    run_div("s8000_2",   16'h8000,  16'd2,     1'b1, 16'hC000,  16'h0000,  1'b0, 1'b0);
    run_div("uffff_1",   16'hFFFF,  16'd1,     1'b0, 16'hFFFF,  16'h0000,  1'b0, 1'b0);
    run_div("u_dz",      16'h1234,  16'd0,     1'b0, 16'hFFFF,  16'h1234,  1'b1, 1'b0);
    run_div("s_dz",      16'h1234,  16'd0,     1'b1, 16'hFFFF,  16'h1234,  1'b1, 1'b0);
    run_div("s_dzneg",   16'hF000,  16'd0,     1'b1, 16'hFFFF,  16'hF000,  1'b1, 1'b0);

    // Starts during CALC and DONE are dropped; the next IDLE cycle accepts.
    launch(16'd100, 16'd7, 1'b0);
    finish_div("hs", 16'd14, 16'd2, 1'b0, 1'b0, 1'b1);
    chk("hs.noqueue", 32'(busy), 32'd0);
    chk("hs.hold",    32'(quot), 32'd14);
    launch(16'd1000, 16'd9, 1'b0);
    chk("hs.accept", 32'(busy), 32'd1);
    finish_div("hs2", 16'd111, 16'd1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of CALC aborts with no done pulse.
    launch(16'h1234, 16'd3, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.done", 32'(done), 32'd0);
    chk("mid.quot", 32'(quot), 32'd0);
    chk("mid.rem",  32'(rem),  32'd0);
    chk("mid.dz",   32'(dz),   32'd0);
    chk("mid.ov",   32'(ov),   32'd0);
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcnt++;
    end
    chk("mid.nodone", 32'(dcnt), 32'd0);
    run_div("u50_5", 16'd50, 16'd5, 1'b0, 16'd10, 16'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
